// File: rtl/simon_data_out.sv
// SIMON output packetiser: gathers one or two result blocks from the core
// and presents them as a data/count/info byte packet to the external reader.
module simon_data_out #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 newBlock,
    input  logic [1:0][N-1:0]    blockOUT,
    input  logic [7:0]           infoOUT,
    output logic                 loadBlock,
    input  logic                 readPkt,
    output logic                 pktReady,
    output logic [N/2+1:0][7:0]  out,
    output logic [7:0]           countOUT,
    output logic                 err
);

    localparam logic [3:0] MODE_C = 4'(MODE);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        RELEASE,
        BUILD,
        SEND,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0][N-1:0]   words;
    logic [1:0]          info_q;
    logic                half;
    logic                drop;
    logic [7:0]          count_pkt;

    // Key-direction bits of the info byte and M are not needed on this side.
    logic unused_ok;
    assign unused_ok = ^{infoOUT[5:4], 8'(M)};

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (newBlock && !loadBlock) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: state_nx = RELEASE;
            RELEASE: begin
                if (!newBlock) begin
                    if (drop) begin
                        state_nx = IDLE;
                    end else if (info_q[1] && !half) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = BUILD;
                    end
                end
            end
            BUILD: state_nx = SEND;
            SEND: begin
                if (readPkt) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!readPkt) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            words     <= '0;
            info_q    <= '0;
            half      <= 1'b0;
            drop      <= 1'b0;
            count_pkt <= '0;
            err       <= 1'b0;
            loadBlock <= 1'b0;
            pktReady  <= 1'b0;
            out       <= '0;
            countOUT  <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    loadBlock <= 1'b1;
                    if (infoOUT[3:0] != MODE_C) begin
                        err  <= 1'b1;
                        drop <= 1'b1;
                        half <= 1'b0;
                    end else begin
                        drop <= 1'b0;
                        words[{half, 1'b0}] <= blockOUT[0];
                        words[{half, 1'b1}] <= blockOUT[1];
                        // Only the first block of a pair governs the packet.
                        if (!half) begin
                            info_q <= infoOUT[7:6];
                        end
                    end
                end
                RELEASE: begin
                    if (!newBlock) begin
                        loadBlock <= 1'b0;
                        if (!drop && info_q[1] && !half) begin
                            half <= 1'b1;
                        end
                    end
                end
                BUILD: begin
                    out       <= {info_q, 2'b01, MODE_C, count_pkt, words};
                    countOUT  <= count_pkt;
                    count_pkt <= count_pkt + 8'd1;
                    pktReady  <= 1'b1;
                end
                SEND: begin
                    if (readPkt) begin
                        pktReady <= 1'b0;
                        half     <= 1'b0;
                        words    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for simon_data_out (N=16, MODE=0).
// Expected packets are hand-written literals and a running count model.
module tb_simon_data_out;

    logic             clk = 1'b0;
    logic             R;
    logic             newBlock;
    logic [1:0][15:0] blockOUT;
    logic [7:0]       infoOUT;
    logic             loadBlock;
    logic             readPkt;
    logic             pktReady;
    logic [9:0][7:0]  out;
    logic [7:0]       countOUT;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    simon_data_out #(.N(16), .M(4), .MODE(0)) dut (
        .clk       (clk),
        .R         (R),
        .newBlock  (newBlock),
        .blockOUT  (blockOUT),
        .infoOUT   (infoOUT),
        .loadBlock (loadBlock),
        .readPkt   (readPkt),
        .pktReady  (pktReady),
        .out       (out),
        .countOUT  (countOUT),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic put_block(input logic [15:0] w1, input logic [15:0] w0,
                             input logic [7:0] info);
        int n;
        @(negedge clk);
        blockOUT = {w1, w0};
        infoOUT  = info;
        newBlock = 1'b1;
        n = 0;
        while (!loadBlock && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("load_hi", loadBlock, 1'b1);
        newBlock = 1'b0;
        @(negedge clk);
        chk("load_lo", loadBlock, 1'b0);
    endtask

    task automatic wait_pkt();
        int n;
        n = 0;
        while (!pktReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_ready", pktReady, 1'b1);
    endtask

    task automatic ack();
        @(negedge clk);
        readPkt = 1'b1;
        @(negedge clk);
        chk("ack_drop", pktReady, 1'b0);
        readPkt = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_cnt;
        logic       seen;
        R        = 1'b1;
        newBlock = 1'b0;
        blockOUT = '0;
        infoOUT  = '0;
        readPkt  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt", pktReady, 1'b0);
        chk("rst_load", loadBlock, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_out", out, 80'h0);
        chk("rst_cnt", countOUT, 8'h00);
        R = 1'b0;

        // single block, latency and layout
        put_block(16'h6565, 16'h6877, 8'h00);
        chk("lat_early", pktReady, 1'b0);
        @(negedge clk);
        chk("lat_2cyc", pktReady, 1'b1);
        chk("single_out", out, 80'h1000_0000_0000_6565_6877);
        chk("single_b0", out[0], 8'h77);
        chk("single_info", out[9], 8'h10);
        chk("single_cnt", countOUT, 8'h00);
        ack();

        // two blocks; second info[7]=0 must not matter
        put_block(16'h1111, 16'h2222, 8'h80);
        repeat (4) @(negedge clk);
        chk("pair_no_pkt", pktReady, 1'b0);
        put_block(16'h3333, 16'h4444, 8'h00);
        wait_pkt();
        chk("pair_out", out, 80'h9001_3333_4444_1111_2222);
        chk("pair_cnt", countOUT, 8'h01);
        ack();

        // backpressure with a pending packet
        put_block(16'hAAAA, 16'hBBBB, 8'h40);
        wait_pkt();
        chk("bp_first", out, 80'h5002_0000_0000_AAAA_BBBB);
        blockOUT = {16'hCCCC, 16'hDDDD};
        infoOUT  = 8'h00;
        newBlock = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= loadBlock;
        end
        chk("bp_load", seen, 1'b0);
        chk("bp_hold", out, 80'h5002_0000_0000_AAAA_BBBB);
        chk("bp_ready", pktReady, 1'b1);
        readPkt = 1'b1;
        @(negedge clk);
        readPkt = 1'b0;
        begin
            int n;
            n = 0;
            while (!loadBlock && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_capt", loadBlock, 1'b1);
        newBlock = 1'b0;
        @(negedge clk);
        wait_pkt();
        chk("bp_next", out, 80'h1003_0000_0000_CCCC_DDDD);
        ack();

        // mode mismatch is dropped, err sticky
        put_block(16'h9999, 16'h8888, 8'h03);
        repeat (5) @(negedge clk);
        chk("mode_nopkt", pktReady, 1'b0);
        chk("mode_err", err, 1'b1);
        put_block(16'h1234, 16'h5678, 8'h00);
        wait_pkt();
        chk("mode_after", out, 80'h1004_0000_0000_1234_5678);
        chk("mode_sticky", err, 1'b1);

        // asynchronous reset while the packet is pending
        #2 R = 1'b1;
        #1;
        chk("arst_pkt", pktReady, 1'b0);
        chk("arst_load", loadBlock, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_out", out, 80'h0);
        @(negedge clk);
        R = 1'b0;

        // count wrap over 257 packets
        exp_cnt = 8'h00;
        for (int i = 1; i <= 257; i++) begin
            put_block(16'(i), ~16'(i), 8'h00);
            wait_pkt();
            chk("wrap_cnt", countOUT, exp_cnt);
            if (i == 1) chk("arst_cnt0", out[8], 8'h00);
            if (i == 256) chk("wrap_ff", countOUT, 8'hFF);
            if (i == 257) chk("wrap_00", out[8], 8'h00);
            exp_cnt = exp_cnt + 8'd1;
            ack();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/simon_data_out.md
Name: simon_data_out

Overview:
- Output-side packetiser for the SIMON core; the transmit counterpart of the packet-input loader.
- Takes one or two 2-word result blocks from the cipher core via a newBlock/loadBlock handshake.
- Assembles them into an (N/2+2)-byte output packet: data bytes, count byte, info byte.
- Presents the packet to the external interface with a pktReady/readPkt handshake.

Parameters:
- N, 16, word width in bits; multiple of 8. The packet has N/2 data bytes, i.e. four N-bit words.
- M, 4, key words; not used internally, carried for interface parity with the input loader.
- MODE, 0, cipher mode code written to info[3:0] and checked on every block.

Ports:
- clk  in  1  system clock; all logic on posedge.
- R  in  1  asynchronous active-high reset.
- newBlock  in  1  core has a result block on blockOUT; level, held until loadBlock is seen.
- blockOUT  in  2xN  result block; word0 = blockOUT[0], word1 = blockOUT[1].
- infoOUT  in  8  info byte accompanying the block. bit7 = two-block packet; bit6 = user flag; bits3:0 = mode.
- loadBlock  out  1  block captured; held high until newBlock is sampled low.
- readPkt  in  1  external reader acknowledge; level.
- pktReady  out  1  packet valid on out; held until acknowledged.
- out  out  (N/2+2)x8  packet bytes.
- countOUT  out  8  copy of out[N/2].
- err  out  1  sticky mode-mismatch flag.

Behaviour:
- Reset (R=1, asynchronous):
  - state IDLE, half=0, countPkt=0, err=0.
  - loadBlock=0, pktReady=0, out=0, countOUT=0.
  - Asserting R mid-operation discards any partial or pending packet; pktReady falls without waiting for a clock edge.
- Packet layout:
  - Word i occupies bytes i*N/8 .. (i+1)*N/8-1, least-significant byte first.
  - First block goes to words 0,1; second block to words 2,3. Words 2,3 are zero for a single-block packet.
  - byte N/2 = countPkt.
  - byte N/2+1 = {info[7], info[6], 1'b0, 1'b1, MODE[3:0]}: bit5 (key) is forced 0, bit4 (output packet) is forced 1.
- States: IDLE, CAPTURE, RELEASE, BUILD, SEND, DRAIN.
- IDLE:
  - Go to CAPTURE when newBlock=1 and loadBlock=0. Otherwise stay.
  - IDLE is never entered while a packet is unacknowledged, so core blocks are backpressured.
- CAPTURE (1 cycle):
  - Latch blockOUT into words {half,0} and {half,1}; latch infoOUT; set loadBlock=1.
  - If infoOUT[3:0] != MODE: set err=1, mark the block discarded, clear half.
  - Go to RELEASE.
- RELEASE:
  - Hold loadBlock=1 until newBlock=0, then clear loadBlock.
  - Next state:
    - discarded block -> IDLE;
    - info[7]=1 and half=0 -> half<=1, IDLE (await second block);
    - otherwise -> BUILD.
- BUILD (1 cycle):
  - Drive out and countOUT from the latched words, countPkt and info.
  - pktReady<=1; countPkt<=countPkt+1, wrapping 8'hFF -> 8'h00.
  - Go to SEND.
- SEND:
  - Hold out stable with pktReady=1 until readPkt=1.
  - Then pktReady<=0, half<=0, clear words, go to DRAIN.
- DRAIN: wait for readPkt=0, then IDLE. A single long acknowledge must not consume two packets.
- Latency: newBlock falling edge sampled -> pktReady high 2 cycles later (RELEASE->BUILD, BUILD->SEND register).
- Simultaneous events:
  - newBlock while in SEND/DRAIN is ignored until IDLE.
  - readPkt high before pktReady has no effect.
  - A second block's infoOUT[7] is ignored; the first block's info governs the packet.
- out and countOUT keep their last value after acknowledge until the next BUILD. Readers must qualify them with pktReady.

Test Plan:
- Reset: R=1 mid-SEND -> pktReady, loadBlock and err immediately 0; out=0; next packet has count 0x00.
- Single block, N=16, MODE=0: infoOUT=8'h00, blockOUT[0]=16'h6877, blockOUT[1]=16'h6565; drop newBlock after loadBlock -> pktReady 2 cycles later. Required packet:
  - out[0..3]=77,68,65,65; out[4..7]=00;
  - out[8]=00, out[9]=8'h10.
  - readPkt=1 -> pktReady=0.
- Two blocks: infoOUT=8'h80; A={1111,2222} then B={3333,4444} -> no pktReady after A. One packet:
  - words 0..3 = 2222,1111,4444,3333;
  - out[9]=8'h90, count=01.
- Backpressure: hold readPkt=0 for 20 cycles with a pending packet and newBlock=1 -> loadBlock stays 0, out unchanged. Release readPkt pulse -> block captured next.
- Count wrap: send 257 single-block packets -> packet 256 count 8'hFF, packet 257 count 8'h00.
- Mode error: infoOUT=8'h03, MODE=0 -> loadBlock handshake completes, pktReady stays 0, err=1. A following valid block still produces a packet.
